// File: rtl/stage_skid_reg_if.sv
// Handshake bundle for one pipeline stage: the upstream entry port, the
// downstream entry port, the flush control and the two status outputs.
interface stage_skid_reg_if #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic              newpc_o;
  logic [7:0]        drop_cnt;

  // Environment side: feeds entries in, consumes entries out.
  modport master (
    output flush, in_valid, in_pc, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_data, newpc_o, drop_cnt
  );

  // Stage side: the stage_skid_reg block itself.
  modport slave (
    input  flush, in_valid, in_pc, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_data, newpc_o, drop_cnt
  );
endinterface

// File: rtl/stage_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush with a
// saturating discard counter, and a "new PC" pulse on the output side.
module stage_skid_reg #(
  parameter int DATA_W  = 64,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  stage_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              newpc_q, newpc_d;
  logic [7:0]        drop_q, drop_d;

  logic              out_valid_w;
  logic              in_ready_w;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        held;
  logic [8:0]        drop_sum;

  // The main register is zeroed whenever it is not holding an entry, so the
  // outputs show a NOP bubble without extra gating.
  assign out_valid_w = (state_q != EMPTY);
  assign in_ready_w  = SKID_EN ? in_ready_q : (!out_valid_w || bus.out_ready);
  assign in_fire     = bus.in_valid && in_ready_w;
  assign out_fire    = out_valid_w && bus.out_ready;

  assign held     = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
  assign drop_sum = {1'b0, drop_q} + {7'b0, held};

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_data  = main_data_q;
  assign bus.newpc_o   = newpc_q;
  assign bus.drop_cnt  = drop_q;

  // Next-state and datapath selection; flush wins over both transfers and
  // leaves last_pc alone so it never produces a newpc pulse by itself.
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    last_pc_d   = last_pc_q;
    newpc_d     = 1'b0;
    drop_d      = drop_q;

    if (bus.flush) begin
      state_d     = EMPTY;
      main_pc_d   = '0;
      main_data_d = '0;
      skid_pc_d   = '0;
      skid_data_d = '0;
      drop_d      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end else begin
      if (out_fire) begin
        last_pc_d = main_pc_q;
        newpc_d   = (main_pc_q != last_pc_q);
      end
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_pc_d   = bus.in_pc;
            main_data_d = bus.in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d   = bus.in_pc;
            main_data_d = bus.in_data;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_pc_d   = bus.in_pc;
            skid_data_d = bus.in_data;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_pc_d   = '0;
            main_data_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            skid_pc_d   = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      last_pc_q   <= '0;
      newpc_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      last_pc_q   <= last_pc_d;
      newpc_q     <= newpc_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// Bench for stage_skid_reg: one skid-buffered instance and one plain-register
// instance share the same stimulus and are each compared to a small FIFO model.
module tb_stage_skid_reg;

  localparam int DATA_W = 64;
  localparam int PC_W   = 32;

  logic clk;
  logic rst;

  int total;
  int bad;

  // Reference model per instance (0 = skid, 1 = plain): an ordered list of
  // held entries plus the last departed PC, pulse and discard count.
  logic [PC_W-1:0]   m_pc   [2][2];
  logic [DATA_W-1:0] m_data [2][2];
  int                m_cnt  [2];
  logic [PC_W-1:0]   m_last [2];
  logic              m_newpc[2];
  int                m_drop [2];

  stage_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus0 ();
  stage_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus1 ();

  stage_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID_EN(1'b1)) dut_skid (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  stage_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID_EN(1'b0)) dut_plain (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whether instance d accepts an entry given its current occupancy.
  function automatic logic expReady(input int d);
    if (d == 0) return (m_cnt[0] < 2);
    return (m_cnt[1] == 0) || bus1.out_ready;
  endfunction

  // Advance both models by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic rdy, ofire, ifire;
    for (int d = 0; d < 2; d++) begin
      rdy = expReady(d);
      if (rst) begin
        m_cnt[d] = 0; m_last[d] = '0; m_newpc[d] = 1'b0; m_drop[d] = 0;
      end else if (bus0.flush) begin
        m_drop[d]  = (m_drop[d] + m_cnt[d] > 255) ? 255 : m_drop[d] + m_cnt[d];
        m_cnt[d]   = 0;
        m_newpc[d] = 1'b0;
      end else begin
        ofire = (m_cnt[d] > 0) && bus0.out_ready;
        ifire = bus0.in_valid && rdy;
        m_newpc[d] = 1'b0;
        if (ofire) begin
          m_newpc[d]   = (m_pc[d][0] != m_last[d]);
          m_last[d]    = m_pc[d][0];
          m_pc[d][0]   = m_pc[d][1];
          m_data[d][0] = m_data[d][1];
          m_cnt[d]--;
        end
        if (ifire) begin
          m_pc[d][m_cnt[d]]   = bus0.in_pc;
          m_data[d][m_cnt[d]] = bus0.in_data;
          m_cnt[d]++;
        end
      end
    end
  endtask

  // Compare every observable output of instance d against its model.
  task automatic checkDut(input int d, input string nm);
    logic ov, ir, np;
    logic [PC_W-1:0] opc;
    logic [DATA_W-1:0] odat;
    logic [7:0] dc;
    if (d == 0) begin
      ov = bus0.out_valid; ir = bus0.in_ready; np = bus0.newpc_o;
      opc = bus0.out_pc; odat = bus0.out_data; dc = bus0.drop_cnt;
    end else begin
      ov = bus1.out_valid; ir = bus1.in_ready; np = bus1.newpc_o;
      opc = bus1.out_pc; odat = bus1.out_data; dc = bus1.drop_cnt;
    end
    checkOutput({nm, ".out_valid"}, 64'(ov), 64'(m_cnt[d] > 0));
    checkOutput({nm, ".out_pc"}, 64'(opc), (m_cnt[d] > 0) ? 64'(m_pc[d][0]) : 64'd0);
    checkOutput({nm, ".out_data"}, 64'(odat), (m_cnt[d] > 0) ? 64'(m_data[d][0]) : 64'd0);
    checkOutput({nm, ".in_ready"}, 64'(ir), 64'(expReady(d)));
    checkOutput({nm, ".newpc_o"}, 64'(np), 64'(m_newpc[d]));
    checkOutput({nm, ".drop_cnt"}, 64'(dc), 64'(m_drop[d]));
  endtask

  // Drive one cycle of inputs to both instances, clock them, then check.
  task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic ordy,
                               input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] dat);
    rst = r;
    bus0.flush = f; bus0.in_valid = iv; bus0.out_ready = ordy; bus0.in_pc = pc; bus0.in_data = dat;
    bus1.flush = f; bus1.in_valid = iv; bus1.out_ready = ordy; bus1.in_pc = pc; bus1.in_data = dat;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkDut(0, "skid");
    checkDut(1, "plain");
  endtask

  // Directed scenarios first, then a randomized run.
  initial begin
    total = 0;
    bad   = 0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_last[d] = '0; m_newpc[d] = 1'b0; m_drop[d] = 0;
      for (int k = 0; k < 2; k++) begin
        m_pc[d][k] = '0; m_data[d][k] = '0;
      end
    end

    // Reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("reset.in_ready", 64'(bus0.in_ready), 64'd1);

    // Streaming 0x00, 0x04, 0x08.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, PC_W'(i * 4), 64'hA000 + 64'(i));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Backpressure: three pushes against a stalled output, then drain.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, (i < 3), 1'b0, PC_W'(32'h10 + 32'(i) * 4), 64'hB000 + 64'(i));
    checkOutput("bp.in_ready_low", 64'(bus0.in_ready), 64'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Flush when full, with a same-cycle input that must vanish.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 64'hC000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 64'hC001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h48, 64'hC002);
    checkOutput("flush.drop", 64'(bus0.drop_cnt), 64'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Repeated PC 0x20 back-to-back.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 64'hD000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 64'hD001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    // Saturation: 130 flushes of a full stage.
    for (int i = 0; i < 130; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, PC_W'(i), 64'(i));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, PC_W'(i + 1), 64'(i + 1));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    checkOutput("sat.drop", 64'(bus0.drop_cnt), 64'd255);

    // Reset mid-FULL under backpressure: contents discarded, nothing counted.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 64'hE000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h64, 64'hE001);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h68, 64'hE002);
    checkOutput("rstfull.drop", 64'(bus0.drop_cnt), 64'd0);
    checkOutput("rstfull.out_valid", 64'(bus0.out_valid), 64'd0);

    // Randomized traffic with a small PC alphabet so repeats occur.
    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                    1'($urandom), ($urandom_range(0, 3) != 0),
                    PC_W'($urandom_range(0, 7) * 4), {$urandom, $urandom});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
